// File: rtl/instr_loader.sv
// Assembles big-endian bytes from the debug receiver into instruction words and writes them
// to instruction memory at byte addresses 0, 4, 8, ... Define LOADER_TIMEOUT_EN to add the inter-byte timeout.
module instr_loader #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    MEM_DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD      = 32'hFFFFFFFF,
    parameter int                    TIMEOUT_CYCLES = 100000,
    localparam int                   CW             = $clog2(MEM_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
`ifdef LOADER_TIMEOUT_EN
    output logic                  o_timeout,
`endif
    output logic [CW-1:0]         o_word_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-9:0] asm_reg;
    logic [ADDR_WIDTH-1:0] next_addr;

    logic last_word;
    logic halt_hit;
    logic finish_load;

    // The word being written in this o_wr_en cycle is the last one if it is the halt word or fills memory.
    assign last_word   = (o_word_count == CW'(MEM_DEPTH - 1));
    assign halt_hit    = (o_wr_data == HALT_WORD);
    assign finish_load = o_wr_en && (halt_hit || last_word);

    assign o_busy = (state == ST_RECV);
    assign o_done = (state == ST_DONE);

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
`endif

    // NOTE: reset is sampled inside the clocked block, so it is synchronous and overrides every other input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            byte_idx     <= 2'd0;
            asm_reg      <= '0;
            next_addr    <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
`ifdef LOADER_TIMEOUT_EN
            idle_cnt     <= '0;
            o_timeout    <= 1'b0;
`endif
        end else begin
            // NOTE: o_wr_en defaults low every cycle, so the strobe can never stretch past one cycle.
            o_wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state        <= ST_RECV;
                        byte_idx     <= 2'd0;
                        asm_reg      <= '0;
                        next_addr    <= '0;
                        o_wr_addr    <= '0;
                        o_overflow   <= 1'b0;
                        o_word_count <= '0;
`ifdef LOADER_TIMEOUT_EN
                        idle_cnt     <= '0;
                        o_timeout    <= 1'b0;
`endif
                    end
                end
                ST_RECV: begin
                    if (o_wr_en) begin
                        next_addr    <= next_addr + ADDR_WIDTH'(4);
                        o_word_count <= o_word_count + CW'(1);
                        if (halt_hit) begin
                            state <= ST_DONE;
                        end else if (last_word) begin
                            state      <= ST_DONE;
                            o_overflow <= 1'b1;
                        end
                    end
                    // A byte in the write cycle becomes b0 of the next word unless loading just ended.
                    if (i_rx_valid && !finish_load) begin
                        if (byte_idx == 2'd3) begin
                            o_wr_en   <= 1'b1;
                            o_wr_data <= {asm_reg, i_rx_data};
                            o_wr_addr <= next_addr;
                            asm_reg   <= '0;
                        end else begin
                            asm_reg <= {asm_reg[DATA_WIDTH-17:0], i_rx_data};
                        end
                        byte_idx <= byte_idx + 2'd1;
                    end
`ifdef LOADER_TIMEOUT_EN
                    if (i_rx_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != TW'(TIMEOUT_CYCLES)) begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end else if (byte_idx != 2'd0) begin
                        state     <= ST_DONE;
                        o_timeout <= 1'b1;
                        byte_idx  <= 2'd0;
                        asm_reg   <= '0;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a 256-word instance for load/stream/restart cases and a 4-word one for overflow.
module tb_instr_loader;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;

    logic        b_wr_en, b_busy, b_done, b_ovf;
    logic [31:0] b_wr_addr, b_wr_data;
    logic [8:0]  b_wc;
    logic        s_wr_en, s_busy, s_done, s_ovf;
    logic [31:0] s_wr_addr, s_wr_data;
    logic [2:0]  s_wc;
`ifdef LOADER_TIMEOUT_EN
    logic        b_timeout, s_timeout;
`endif

    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    instr_loader #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf),
`ifdef LOADER_TIMEOUT_EN
        .o_timeout(b_timeout),
`endif
        .o_word_count(b_wc)
    );

    instr_loader #(.MEM_DEPTH(4), .TIMEOUT_CYCLES(16)) dut_small (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
        .o_busy(s_busy), .o_done(s_done), .o_overflow(s_ovf),
`ifdef LOADER_TIMEOUT_EN
        .o_timeout(s_timeout),
`endif
        .o_word_count(s_wc)
    );

    // Write log of the large instance plus edge numbers of byte strobes and write cycles.
    int          cyc = 0;
    int          byte_edge[$];
    int          wcyc[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          dbl = 0;
    logic        prev_we = 1'b0;
    int          s_cnt = 0;
    logic [31:0] s_max = 32'h0;

    always @(posedge i_clk) begin
        if (i_rx_valid) byte_edge.push_back(cyc);
        cyc = cyc + 1;
    end

    always @(negedge i_clk) begin
        if (b_wr_en) begin
            wa.push_back(b_wr_addr);
            wd.push_back(b_wr_data);
            wcyc.push_back(cyc);
            if (prev_we) dbl = dbl + 1;
        end
        prev_we = b_wr_en;
        if (s_wr_en) begin
            s_cnt = s_cnt + 1;
            if (s_wr_addr > s_max) s_max = s_wr_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send(w[31-8*k -: 8]);
            tick(gap);
        end
    endtask

    task automatic do_reset();
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        tick(2);
        i_reset = 1'b0;
        tick(1);
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wcyc.delete();
        byte_edge.delete();
        dbl   = 0;
        s_cnt = 0;
        s_max = 32'h0;
    endtask

    logic [31:0] words [4];

    initial begin
        // Basic load ending in a halt word
        do_reset();
        check("rst_busy", b_busy, 0);
        check("rst_done", b_done, 0);
        check("rst_wr_en", b_wr_en, 0);
        check("rst_wc", b_wc, 0);
        check("rst_ovf", b_ovf, 0);
        check("rst_addr", b_wr_addr, 0);
        check("rst_data", b_wr_data, 0);
        start_pulse();
        check("start_busy", b_busy, 1);
        clear_log();
        send_word(32'h20080005, 2);
        send(8'hFF); tick(1);
        send(8'hFF); tick(1);
        send(8'hFF); tick(1);
        send(8'hFF);
        @(negedge i_clk);
        check("halt_we", b_wr_en, 1);
        check("halt_done_low", b_done, 0);
        @(negedge i_clk);
        check("halt_done_high", b_done, 1);
        check("halt_we_low", b_wr_en, 0);
        tick(2);
        check("t1_nwr", wa.size(), 2);
        check("t1_a0", wa[0], 32'h0);
        check("t1_d0", wd[0], 32'h20080005);
        check("t1_a1", wa[1], 32'h4);
        check("t1_d1", wd[1], 32'hFFFFFFFF);
        check("t1_wc", b_wc, 2);
        check("t1_ovf", b_ovf, 0);
        check("t1_busy", b_busy, 0);

        // Back-to-back bytes, three words plus halt
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC;
        words[3] = 32'hFFFFFFFF;
        do_reset();
        start_pulse();
        clear_log();
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++)
                send(words[w][31-8*k -: 8]);
        tick(3);
        check("t2_nbytes", byte_edge.size(), 16);
        check("t2_nwr", wa.size(), 4);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("t2_a%0d", w), wa[w], 32'(4 * w));
            check($sformatf("t2_d%0d", w), wd[w], words[w]);
            check($sformatf("t2_lat%0d", w), wcyc[w], byte_edge[4*w+3] + 1);
        end
        check("t2_dbl", dbl, 0);
        check("t2_done", b_done, 1);
        check("t2_wc", b_wc, 4);

        // Overflow of a 4-word memory
        do_reset();
        start_pulse();
        clear_log();
        for (int w = 0; w < 4; w++) send_word(32'h10000001 + 32'(w), 1);
        tick(3);
        check("t3_ncnt", s_cnt, 4);
        check("t3_maxaddr", s_max, 32'hC);
        check("t3_ovf", s_ovf, 1);
        check("t3_done", s_done, 1);
        check("t3_wc", s_wc, 4);
        send_word(32'h12345678, 1);
        tick(3);
        check("t3_no5th", s_cnt, 4);
        check("t3_busy", s_busy, 0);

        // Reset in the middle of a word
        do_reset();
        start_pulse();
        send(8'h12);
        send(8'h34);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        clear_log();
        check("t4_rst_busy", b_busy, 0);
        start_pulse();
        send_word(32'hAABBCCDD, 0);
        tick(3);
        check("t4_nwr", wa.size(), 1);
        check("t4_a0", wa[0], 32'h0);
        check("t4_d0", wd[0], 32'hAABBCCDD);

        // Bytes in IDLE, start mid-load, then restart from DONE
        do_reset();
        clear_log();
        send_word(32'h01020304, 0);
        tick(2);
        check("t5_idle_nwr", wa.size(), 0);
        check("t5_idle_busy", b_busy, 0);
        start_pulse();
        send_word(32'hDEADBEEF, 1);
        start_pulse();
        send(8'hCA); send(8'hFE);
        start_pulse();
        send(8'hF0); send(8'h0D);
        tick(1);
        send_word(32'hFFFFFFFF, 0);
        tick(3);
        check("t5_nwr", wa.size(), 3);
        check("t5_a1", wa[1], 32'h4);
        check("t5_d1", wd[1], 32'hCAFEF00D);
        check("t5_a2", wa[2], 32'h8);
        check("t5_wc", b_wc, 3);
        start_pulse();
        check("t5_re_wc", b_wc, 0);
        check("t5_re_busy", b_busy, 1);
        check("t5_re_done", b_done, 0);
        clear_log();
        send_word(32'h0A0B0C0D, 1);
        tick(2);
        check("t5_re_nwr", wa.size(), 1);
        check("t5_re_a0", wa[0], 32'h0);
        check("t5_re_d0", wd[0], 32'h0A0B0C0D);
        check("t5_re_wc1", b_wc, 1);

`ifdef LOADER_TIMEOUT_EN
        // Partial word followed by silence
        do_reset();
        start_pulse();
        clear_log();
        send(8'h55);
        send(8'h66);
        tick(10);
        check("t6_busy_early", b_busy, 1);
        tick(10);
        check("t6_done", b_done, 1);
        check("t6_timeout", b_timeout, 1);
        check("t6_nwr", wa.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Writer-side counterpart to the IF stage fetch path. Assembles bytes from the debug/UART receiver into 32-bit instruction words and writes them to instruction memory at byte addresses 0, 4, 8, and so on. These are the same byte-address steps the program counter walks.
Loading ends when the halt word is written or memory fills. The CPU pipeline is held while o_busy is high.

Parameters:
- DATA_WIDTH, 32, instruction word width (fixed at 4 bytes).
- ADDR_WIDTH, 32, byte-address width of o_wr_addr, matching PC width.
- MEM_DEPTH, 256, instruction memory depth in words.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.
- TIMEOUT_CYCLES, 100000, inter-byte timeout. Used only with the optional feature.

Ports:
- i_clk, input, 1: clock. All logic is on the posedge.
- i_reset, input, 1: synchronous, active-high reset.
- i_start, input, 1: level or pulse. Begins a load from address 0.
- i_rx_data, input, 8: received byte.
- i_rx_valid, input, 1: one-cycle strobe. Qualifies i_rx_data.
- o_wr_en, output, 1: one-cycle instruction memory write strobe.
- o_wr_addr, output, ADDR_WIDTH: byte address of the write. Always a multiple of 4.
- o_wr_data, output, DATA_WIDTH: word to write.
- o_busy, output, 1: high in the RECV state.
- o_done, output, 1: high in the DONE state.
- o_overflow, output, 1: sticky. Memory filled without a halt word.
- o_word_count, output, $clog2(MEM_DEPTH)+1: number of words written in the current load.

Behaviour:
- Reset (i_reset=1 at a posedge): state=IDLE; all outputs 0; byte index=0; assembly register=0. Reset wins over every other input, including mid-word and mid-write.
- States: IDLE, RECV, DONE.
- IDLE:
  - i_rx_valid is ignored.
  - i_start=1 moves to RECV, clears the address, word count, byte index and o_overflow.
- RECV:
  - Each i_rx_valid shifts a byte in. The first byte is MSB (big-endian): word = {b0,b1,b2,b3}.
  - The byte index counts 0..3.
  - On the 4th byte, the next cycle has o_wr_en=1, o_wr_data=word, o_wr_addr=current address. That is one cycle of latency from the 4th strobe.
  - After the write: address += 4, word count += 1, byte index back to 0.
- Back-to-back bytes: i_rx_valid may be high every cycle. A byte arriving in the o_wr_en cycle is captured as b0 of the next word, and no byte is lost. The output data register is separate from the assembly register.
- Halt: if the written word == HALT_WORD, it is still written. The state then goes to DONE in the same cycle that o_wr_en is high, so o_done rises the following cycle.
- Overflow: if a write lands at word MEM_DEPTH-1 and the word is not HALT_WORD:
  - the state goes to DONE and o_overflow=1;
  - further bytes are ignored;
  - no write ever targets a byte address of MEM_DEPTH*4 or above.
- DONE:
  - o_done=1; o_wr_en=0; i_rx_valid is ignored.
  - o_wr_addr and o_word_count hold their final values.
  - i_start=1 restarts as in IDLE.
- i_start while in RECV is ignored. No restart mid-load.
- Partial-word bytes are discarded on reset only. Without the optional feature, RECV waits indefinitely.
- o_wr_en is never high for more than one consecutive cycle per word.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - In RECV, a cycle counter clears on every i_rx_valid.
  - If it reaches TIMEOUT_CYCLES with byte index != 0, the partial word is discarded and the state goes to DONE.
  - A sticky output o_timeout (1 bit, reset 0, cleared on i_start) is raised.
  - A timeout with byte index == 0 does nothing.
- Undefined:
  - No counter and no o_timeout port.
  - RECV waits forever for bytes.

Test Plan:
- Reset then i_start, bytes 20,08,00,05 then FF,FF,FF,FF -> write 0x20080005 @0x0, write 0xFFFFFFFF @0x4; o_done=1, o_word_count=2, o_overflow=0.
- Bytes streamed with i_rx_valid high every cycle for 3 words plus halt -> 4 writes at 0x0, 0x4, 0x8, 0xC; each o_wr_en exactly one cycle after its 4th byte; no byte dropped.
- MEM_DEPTH=4, 4 non-halt words -> writes at 0x0..0xC, then DONE with o_overflow=1; a 5th word sent produces no o_wr_en.
- i_reset asserted after 2 bytes of a word, then i_start and 4 bytes AA,BB,CC,DD -> single write 0xAABBCCDD @0x0.
- i_start pulsed mid-load and i_rx_valid pulsed in IDLE -> no address reset, no writes from the IDLE bytes; a re-start from DONE begins again at 0x0 with o_word_count=0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: 2 bytes then silence -> after 16 cycles DONE, o_timeout=1, no write issued.
